// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: sample/coefficient/status bundle for the CIC droop-compensation FIR.
interface cic_comp_fir_if #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int AW         = 3
);
  logic                         in_valid;
  logic signed [WIDTH-1:0]      in_data;
  logic                         coef_wr;
  logic [AW-1:0]                coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic                         clear_status;
  logic                         out_valid;
  logic signed [WIDTH-1:0]      out_data;
  logic                         busy;
  logic                         overrun;
  logic                         coef_err;
  modport master (
    output in_valid, in_data, coef_wr, coef_addr, coef_data, clear_status,
    input  out_valid, out_data, busy, overrun, coef_err
  );
  modport slave (
    input  in_valid, in_data, coef_wr, coef_addr, coef_data, clear_status,
    output out_valid, out_data, busy, overrun, coef_err
  );
endinterface

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric odd-length droop-compensation FIR, one pre-added multiply per cycle.
// Define CIC_COMP_FIR_SAT_EN to saturate out_data instead of wrapping.
module cic_comp_fir #(
  parameter int WIDTH      = 16,
  parameter int N_TAPS     = 11,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14
) (
  input logic           clk,
  input logic           reset,
  cic_comp_fir_if.slave bus
);
  localparam int H     = (N_TAPS + 1) / 2;
  localparam int AW    = (H > 1) ? $clog2(H) : 1;
  localparam int KW    = $clog2(H + 1);
  localparam int PW    = $clog2(N_TAPS);
  localparam int PRW   = WIDTH + 1 + COEF_WIDTH;
  localparam int ACC_W = PRW + AW;
  typedef enum logic [1:0] {IDLE, WRITE, MAC, ROUND} state_t;
  state_t                       r_state, w_next;
  logic signed [WIDTH-1:0]      r_buf [N_TAPS];
  logic signed [COEF_WIDTH-1:0] r_coef [H];
  logic [PW-1:0]                r_wp;
  logic [KW-1:0]                r_k;
  logic signed [WIDTH-1:0]      r_in;
  logic signed [PRW-1:0]        r_prod;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [WIDTH-1:0]      r_out;
  logic                         r_out_valid, r_overrun, r_coef_err;
  logic                         w_busy, w_centre;
  logic [PW:0]                  w_ia_raw, w_ib_raw;
  logic [PW-1:0]                w_ia, w_ib;
  logic [AW-1:0]                w_ci;
  logic signed [WIDTH-1:0]      w_xb;
  logic signed [WIDTH:0]        w_pre;
  logic signed [PRW-1:0]        w_mul;
  logic signed [ACC_W-1:0]      w_rnd, w_y;
  logic signed [WIDTH-1:0]      w_y_n;
  // Pointer already advanced past the newest sample: x[k] at wp-1-k, x[N-1-k] at wp+k.
  assign w_ia_raw = {1'b0, r_wp} + (PW+1)'(N_TAPS - 1) - (PW+1)'(r_k);
  assign w_ib_raw = {1'b0, r_wp} + (PW+1)'(r_k);
  assign w_ia     = (w_ia_raw >= (PW+1)'(N_TAPS)) ? PW'(w_ia_raw - (PW+1)'(N_TAPS)) : w_ia_raw[PW-1:0];
  assign w_ib     = (w_ib_raw >= (PW+1)'(N_TAPS)) ? PW'(w_ib_raw - (PW+1)'(N_TAPS)) : w_ib_raw[PW-1:0];
  assign w_centre = (r_k == KW'(H - 1));
  assign w_xb     = w_centre ? '0 : r_buf[w_ib];
  assign w_pre    = (WIDTH+1)'(r_buf[w_ia]) + (WIDTH+1)'(w_xb);
  assign w_ci     = (r_k < KW'(H)) ? AW'(r_k) : '0;
  assign w_mul    = PRW'(w_pre) * PRW'(r_coef[w_ci]);
  assign w_rnd    = r_acc + ACC_W'(2 ** (COEF_FRAC - 1));
  assign w_y      = w_rnd >>> COEF_FRAC;
`ifdef CIC_COMP_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
  assign w_y_n = (w_y > Y_MAX) ? Y_MAX[WIDTH-1:0] : (w_y < Y_MIN) ? Y_MIN[WIDTH-1:0] : w_y[WIDTH-1:0];
`else
  assign w_y_n = w_y[WIDTH-1:0];
`endif
  assign w_busy = (r_state != IDLE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.in_valid ? WRITE : IDLE;
      WRITE:   w_next = MAC;
      MAC:     w_next = (r_k == KW'(H)) ? ROUND : MAC;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // MAC runs H+1 cycles: the product is registered, so the last one is absorbed a cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp        <= '0;
      r_k         <= '0;
      r_in        <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_coef_err  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) r_buf[i] <= '0;
      for (int i = 0; i < H; i++) r_coef[i] <= (i == H - 1) ? COEF_WIDTH'(2 ** COEF_FRAC) : '0;
    end else begin
      r_out_valid <= (r_state == ROUND);
      if (r_state == IDLE && bus.in_valid) r_in <= bus.in_data;
      if (r_state == WRITE) begin
        r_buf[r_wp] <= r_in;
        r_wp        <= (r_wp == PW'(N_TAPS - 1)) ? '0 : r_wp + PW'(1);
        r_k         <= '0;
        r_prod      <= '0;
        r_acc       <= '0;
      end
      if (r_state == MAC) begin
        r_k    <= r_k + KW'(1);
        r_prod <= w_mul;
        r_acc  <= r_acc + ACC_W'(r_prod);
      end
      if (r_state == ROUND) r_out <= w_y_n;
      if (bus.coef_wr && !w_busy && ({1'b0, bus.coef_addr} < (AW+1)'(H)))
        r_coef[bus.coef_addr] <= bus.coef_data;
      r_overrun  <= (bus.in_valid & w_busy) | (r_overrun & ~bus.clear_status);
      r_coef_err <= (bus.coef_wr & w_busy) | (r_coef_err & ~bus.clear_status);
    end
  end
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out;
  assign bus.busy      = w_busy;
  assign bus.overrun   = r_overrun;
  assign bus.coef_err  = r_coef_err;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed vectors with hand-computed outputs for the compensation FIR.
module tb_cic_comp_fir;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_ov  = 0;
  int   p0;
`ifdef CIC_COMP_FIR_SAT_EN
  localparam int S4_POS = 32767;
  localparam int S4_NEG = -32768;
`else
  localparam int S4_POS = -5538;
  localparam int S4_NEG = 5538;
`endif
  cic_comp_fir_if #(.WIDTH(16), .COEF_WIDTH(16), .AW(3)) bus ();
  cic_comp_fir #(.WIDTH(16), .N_TAPS(11), .COEF_WIDTH(16), .COEF_FRAC(14)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.out_valid) n_ov++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    tick;
  endtask
  task automatic wr_coef(input int a, input int d);
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = 16'(d);
    tick;
    bus.coef_wr   = 1'b0;
  endtask
  task automatic send(input int x, input int exp, input string tag);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(x);
    tick;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_lat"}, n, 9);
    check(tag, bus.out_data, exp);
  endtask
  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.coef_wr = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.clear_status = 1'b0;
    tick;
    tick;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_coef_err", bus.coef_err, 0);
    reset = 1'b1;
    tick;
    for (int i = 1; i <= 11; i++)
      send((i == 1) ? 1000 : 0, (i == 6) ? 1000 : 0, $sformatf("s1_%0d", i));
    do_reset;
    for (int a = 0; a < 6; a++) wr_coef(a, 1024);
    for (int i = 1; i <= 12; i++)
      send(16384, 1024 * ((i > 11) ? 11 : i), $sformatf("s2_%0d", i));
    do_reset;
    wr_coef(5, 8192);
    for (int i = 1; i <= 8; i++)
      send((i == 1) ? 3 : (i == 2) ? -3 : (i == 3) ? 5 : 0,
           (i == 6) ? 2 : (i == 7) ? -1 : (i == 8) ? 3 : 0, $sformatf("s3_%0d", i));
    do_reset;
    wr_coef(5, 32767);
    for (int i = 1; i <= 7; i++)
      send((i == 1) ? 30000 : (i == 2) ? -30000 : 0,
           (i == 6) ? S4_POS : (i == 7) ? S4_NEG : 0, $sformatf("s4_%0d", i));
    do_reset;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd1000;
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'sd500;
    bus.coef_wr   = 1'b1;
    bus.coef_addr = 3'd5;
    bus.coef_data = '0;
    p0 = n_ov;
    tick;
    bus.in_valid = 1'b0;
    bus.coef_wr  = 1'b0;
    repeat (12) tick;
    check("s5_one_out", n_ov - p0, 1);
    check("s5_overrun", bus.overrun, 1);
    check("s5_coef_err", bus.coef_err, 1);
    for (int i = 1; i <= 5; i++) send(0, (i == 5) ? 1000 : 0, $sformatf("s5_%0d", i));
    bus.clear_status = 1'b1;
    tick;
    bus.clear_status = 1'b0;
    check("s5_clr_overrun", bus.overrun, 0);
    check("s5_clr_coef_err", bus.coef_err, 0);
    do_reset;
    wr_coef(5, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd1000;
    tick;
    bus.in_valid = 1'b0;
    repeat (3) tick;
    check("s6_busy_pre", bus.busy, 1);
    p0 = n_ov;
    reset = 1'b0;
    #1;
    check("s6_out_valid", bus.out_valid, 0);
    check("s6_busy", bus.busy, 0);
    tick;
    reset = 1'b1;
    repeat (12) tick;
    check("s6_no_out", n_ov - p0, 0);
    for (int i = 1; i <= 6; i++)
      send((i == 1) ? 1000 : 0, (i == 6) ? 1000 : 0, $sformatf("s6_%0d", i));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
